// File: rtl/ahb_bus_matrix_arbiter_param.sv
// ---------------------------------------------------------------------------
// ahb_bus_matrix_arbiter_param
//
// Output-stage arbiter for one AHB bus-matrix slave port. Picks which of
// NUM_PORTS input stages drives the shared slave port. It keeps the grant
// for locked transfers, for fixed-length bursts, and for a configurable
// number of beats of undefined-length INCR bursts.
//
// Ports
//   HCLK          in   AHB clock
//   HRESETn       in   asynchronous active-low reset
//   req_port      in   per-port request, bit i = input port i
//   HREADYM       in   slave-side transfer done; all state advances only when high
//   HSELM         in   slave select of the current output transfer
//   HTRANSM       in   transfer type of the current output transfer
//   HBURSTM       in   burst type of the current output transfer
//   HMASTLOCKM    in   locked transfer
//   addr_in_port  out  index of the granted port (registered)
//   no_port       out  no port granted (registered)
//   hold_active   out  registered burst-hold flag
//
// Tracked state
//   r_no_port / r_addr | current grant (no_port=1 forces addr=0)
//   r_hold / r_remain  | burst hold and remaining SEQ beats before release
//   r_early            | INCR bursts that arrived while a hold was still live
// ---------------------------------------------------------------------------
module ahb_bus_matrix_arbiter_param #(
  parameter int NUM_PORTS        = 4,
  parameter int PORT_W           = 2,
  parameter int ARB_MODE         = 0,
  parameter int INCR_HOLD_BEATS  = 4,
  parameter int EARLY_INCR_LIMIT = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 hold_active
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam bit         INCR_HOLD_EN = (INCR_HOLD_BEATS >= 2);
  localparam logic [3:0] INCR_REM     = INCR_HOLD_EN ? 4'(INCR_HOLD_BEATS - 2) : 4'd0;
  localparam logic [1:0] EARLY_LIM    = 2'(EARLY_INCR_LIMIT);

  logic [PORT_W-1:0] r_addr;
  logic              r_no_port;
  logic              r_hold;
  logic [3:0]        r_remain;
  logic [1:0]        r_early;

  logic [PORT_W-1:0] w_addr_nxt;
  logic              w_no_port_nxt;
  logic              w_hold_nxt;
  logic [3:0]        w_remain_nxt;
  logic [1:0]        w_early_nxt;

  // Burst tracking: remain counts the SEQ beats still to come after the
  // current one; the hold drops on the SEQ beat that finds remain at zero.
  always_comb begin
    w_remain_nxt = r_remain;
    w_hold_nxt   = r_hold;
    if (!HSELM) begin
      w_remain_nxt = 4'd0;
      w_hold_nxt   = 1'b0;
    end else begin
      case (HTRANSM)
        TR_IDLE: begin
          w_remain_nxt = 4'd0;
          w_hold_nxt   = 1'b0;
        end
        TR_BUSY: begin
          w_remain_nxt = r_remain;
          w_hold_nxt   = r_hold;
        end
        TR_SEQ: begin
          if (r_remain == 4'd0) begin
            w_hold_nxt = 1'b0;
          end else begin
            w_remain_nxt = r_remain - 4'd1;
          end
        end
        default: begin
          case (HBURSTM)
            3'b110, 3'b111: begin
              w_remain_nxt = 4'd14;
              w_hold_nxt   = 1'b1;
            end
            3'b100, 3'b101: begin
              w_remain_nxt = 4'd6;
              w_hold_nxt   = 1'b1;
            end
            3'b010, 3'b011: begin
              w_remain_nxt = 4'd2;
              w_hold_nxt   = 1'b1;
            end
            3'b001: begin
              // Repeated short INCR bursts would otherwise starve the
              // other ports, so the hold is refused once the limit is hit.
              if (!INCR_HOLD_EN || (r_early == EARLY_LIM)) begin
                w_remain_nxt = 4'd0;
                w_hold_nxt   = 1'b0;
              end else begin
                w_remain_nxt = INCR_REM;
                w_hold_nxt   = 1'b1;
              end
            end
            default: begin
              w_remain_nxt = 4'd0;
              w_hold_nxt   = 1'b0;
            end
          endcase
        end
      endcase
    end
  end

  always_comb begin
    w_early_nxt = r_early;
    if (!w_hold_nxt) begin
      w_early_nxt = 2'd0;
    end else if (r_hold && (HTRANSM == TR_NONSEQ)) begin
      w_early_nxt = (r_early >= EARLY_LIM) ? EARLY_LIM : r_early + 2'd1;
    end
  end

  // Arbitration. Lowest requester above / below the current port is found
  // in one pass; a round-robin wrap search is "above first, then below".
  // The current port's own request bit is deliberately left out.
  logic [PORT_W-1:0] w_any;
  logic [PORT_W-1:0] w_above;
  logic [PORT_W-1:0] w_below;
  logic              w_any_v;
  logic              w_above_v;
  logic              w_below_v;
  logic              w_cur_ok;
  int                w_cur;

  always_comb begin
    w_any     = '0;
    w_above   = '0;
    w_below   = '0;
    w_any_v   = 1'b0;
    w_above_v = 1'b0;
    w_below_v = 1'b0;
    w_cur     = int'(r_addr);
    w_cur_ok  = (w_cur < NUM_PORTS);
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_port[i]) begin
        if (!w_any_v) begin
          w_any   = PORT_W'(i);
          w_any_v = 1'b1;
        end
        if ((i < w_cur) && !w_below_v) begin
          w_below   = PORT_W'(i);
          w_below_v = 1'b1;
        end
        if ((i > w_cur) && !w_above_v) begin
          w_above   = PORT_W'(i);
          w_above_v = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_addr_nxt    = '0;
    w_no_port_nxt = 1'b1;
    if (!r_no_port && !w_cur_ok) begin
      // Out-of-range grant index cannot occur; fall back to reset-equivalent.
      w_addr_nxt    = '0;
      w_no_port_nxt = 1'b1;
    end else if (HMASTLOCKM || w_hold_nxt) begin
      w_addr_nxt    = r_addr;
      w_no_port_nxt = 1'b0;
    end else if (r_no_port) begin
      w_addr_nxt    = w_any;
      w_no_port_nxt = !w_any_v;
    end else if (ARB_MODE == 0) begin
      if (w_above_v) begin
        w_addr_nxt    = w_above;
        w_no_port_nxt = 1'b0;
      end else if (w_below_v) begin
        w_addr_nxt    = w_below;
        w_no_port_nxt = 1'b0;
      end else if (HSELM) begin
        w_addr_nxt    = r_addr;
        w_no_port_nxt = 1'b0;
      end
    end else begin
      if (w_below_v) begin
        w_addr_nxt    = w_below;
        w_no_port_nxt = 1'b0;
      end else if (HSELM) begin
        w_addr_nxt    = r_addr;
        w_no_port_nxt = 1'b0;
      end else if (w_above_v) begin
        w_addr_nxt    = w_above;
        w_no_port_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr    <= '0;
      r_no_port <= 1'b1;
      r_hold    <= 1'b0;
      r_remain  <= 4'd0;
      r_early   <= 2'd0;
    end else if (HREADYM) begin
      r_addr    <= w_addr_nxt;
      r_no_port <= w_no_port_nxt;
      r_hold    <= w_hold_nxt;
      r_remain  <= w_remain_nxt;
      r_early   <= w_early_nxt;
    end
  end

  assign addr_in_port = r_addr;
  assign no_port      = r_no_port;
  assign hold_active  = r_hold;

endmodule

// File: tb/tb_ahb_bus_matrix_arbiter_param.sv
// Bench for ahb_bus_matrix_arbiter_param: a round-robin instance and a
// fixed-priority instance share one stimulus stream; a behavioural model of
// each is stepped alongside and every output is compared after each edge.
module tb_ahb_bus_matrix_arbiter_param;

  localparam int NP = 4;

  logic          HCLK;
  logic          HRESETn;
  logic [NP-1:0] req_port;
  logic          HREADYM;
  logic          HSELM;
  logic [1:0]    HTRANSM;
  logic [2:0]    HBURSTM;
  logic          HMASTLOCKM;

  logic [1:0] addr0, addr1;
  logic       nop0, nop1, hold0, hold1;

  int n_checks = 0;
  int n_fail   = 0;

  // per-instance configuration: mode, INCR hold beats, early limit
  int P_MODE[2] = '{0, 1};
  int P_HB[2]   = '{4, 3};
  int P_LIM[2]  = '{1, 2};

  int m_addr[2], m_nop[2], m_hold[2], m_rem[2], m_early[2];

  ahb_bus_matrix_arbiter_param #(
    .NUM_PORTS(NP), .PORT_W(2), .ARB_MODE(0),
    .INCR_HOLD_BEATS(4), .EARLY_INCR_LIMIT(1)
  ) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr0), .no_port(nop0), .hold_active(hold0)
  );

  ahb_bus_matrix_arbiter_param #(
    .NUM_PORTS(NP), .PORT_W(2), .ARB_MODE(1),
    .INCR_HOLD_BEATS(3), .EARLY_INCR_LIMIT(2)
  ) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr1), .no_port(nop1), .hold_active(hold1)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // number of beats of a burst type; 0 = undefined-length INCR
  function automatic int burst_len(input int b);
    case (b)
      0:       return 1;
      1:       return 0;
      2, 3:    return 4;
      4, 5:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic bit req_at(input int p);
    return ((int'(req_port) >> p) & 1) != 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = 0; m_nop[k] = 1; m_hold[k] = 0; m_rem[k] = 0; m_early[k] = 0;
    end
  endtask

  task automatic model_next(input int k);
    int rem, hold, early, addr, nop, len, cur, pick, tr;
    if (HREADYM !== 1'b1) return;
    tr   = int'(HTRANSM);
    rem  = m_rem[k];
    hold = m_hold[k];
    if (!HSELM || tr == 0) begin
      rem = 0; hold = 0;
    end else if (tr == 2) begin
      len = burst_len(int'(HBURSTM));
      if (len > 1) begin
        rem = len - 2; hold = 1;
      end else if (len == 1) begin
        rem = 0; hold = 0;
      end else if (P_HB[k] < 2 || m_early[k] == P_LIM[k]) begin
        rem = 0; hold = 0;
      end else begin
        rem = P_HB[k] - 2; hold = 1;
      end
    end else if (tr == 3) begin
      if (rem == 0) hold = 0;
      else rem = rem - 1;
    end
    if (hold == 0) early = 0;
    else if (m_hold[k] == 1 && tr == 2) early = (m_early[k] + 1 > P_LIM[k]) ? P_LIM[k] : m_early[k] + 1;
    else early = m_early[k];

    addr = m_addr[k];
    nop  = m_nop[k];
    if (HMASTLOCKM || hold == 1) begin
      nop = 0;
    end else begin
      pick = -1;
      cur  = m_addr[k];
      if (m_nop[k] == 1) begin
        for (int p = 0; p < NP; p++) if (pick < 0 && req_at(p)) pick = p;
      end else if (P_MODE[k] == 0) begin
        for (int s = 1; s < NP; s++) if (pick < 0 && req_at((cur + s) % NP)) pick = (cur + s) % NP;
        if (pick < 0 && HSELM) pick = cur;
      end else begin
        for (int p = 0; p < cur; p++) if (pick < 0 && req_at(p)) pick = p;
        if (pick < 0 && HSELM) pick = cur;
        for (int p = cur + 1; p < NP; p++) if (pick < 0 && req_at(p)) pick = p;
      end
      if (pick < 0) begin
        nop = 1; addr = 0;
      end else begin
        nop = 0; addr = pick;
      end
    end
    m_addr[k] = addr; m_nop[k] = nop; m_hold[k] = hold; m_rem[k] = rem; m_early[k] = early;
  endtask

  task automatic check_model();
    chk("rr_addr", addr0, m_addr[0]);
    chk("rr_noport", nop0, m_nop[0]);
    chk("rr_hold", hold0, m_hold[0]);
    chk("fp_addr", addr1, m_addr[1]);
    chk("fp_noport", nop1, m_nop[1]);
    chk("fp_hold", hold1, m_hold[1]);
  endtask

  task automatic drive(input logic [3:0] rq, input logic sel, input logic [1:0] tr,
                       input logic [2:0] bu, input logic lk, input logic rdy);
    req_port = rq; HSELM = sel; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk; HREADYM = rdy;
  endtask

  task automatic step();
    model_next(0);
    model_next(1);
    @(posedge HCLK);
    #1;
    check_model();
  endtask

  // asynchronous reset pulse between clock edges
  task automatic do_reset();
    HRESETn = 1'b0;
    #1;
    model_reset();
    chk("rst_rr_addr", addr0, 0);
    chk("rst_rr_noport", nop0, 1);
    chk("rst_rr_hold", hold0, 0);
    chk("rst_fp_addr", addr1, 0);
    chk("rst_fp_noport", nop1, 1);
    chk("rst_fp_hold", hold1, 0);
    #1;
    HRESETn = 1'b1;
  endtask

  logic [1:0] s_addr0, s_addr1;
  logic       s_nop0, s_nop1, s_hold0, s_hold1;
  logic [1:0] burst_seq [9];

  initial begin
    HRESETn = 1'b1;
    drive(4'b0000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    #1;
    HRESETn = 1'b0;
    #1;
    model_reset();
    chk("rst0_addr", addr0, 0);
    chk("rst0_noport", nop0, 1);
    chk("rst0_hold", hold0, 0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // first grant from idle
    drive(4'b0100, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step();
    chk("first_grant_addr", addr0, 2);
    chk("first_grant_noport", nop0, 0);

    // round-robin rotation over SINGLE transfers
    do_reset();
    drive(4'b0010, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step();
    chk("rr_start", addr0, 1);
    drive(4'b1101, 1'b1, 2'b10, 3'b000, 1'b0, 1'b1);
    step(); chk("rr_rot1", addr0, 2);
    step(); chk("rr_rot2", addr0, 3);
    step(); chk("rr_rot3", addr0, 0);
    step(); chk("rr_rot4", addr0, 2);

    // INCR8 from port 0: held 8 beats, hold visible for 7
    do_reset();
    drive(4'b0001, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step();
    drive(4'b1110, 1'b1, 2'b10, 3'b101, 1'b0, 1'b1);
    step();
    chk("incr8_hold_b1", hold0, 1);
    for (int b = 2; b <= 7; b++) begin
      drive(4'b1110, 1'b1, 2'b11, 3'b101, 1'b0, 1'b1);
      step();
      chk("incr8_addr_held", addr0, 0);
      chk("incr8_hold_on", hold0, 1);
    end
    step();
    chk("incr8_hold_off", hold0, 0);
    chk("incr8_new_grant", addr0, 1);

    // same burst with a BUSY beat: release moves one beat later
    do_reset();
    drive(4'b0001, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step();
    burst_seq = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    for (int b = 0; b < 9; b++) begin
      drive(4'b1110, 1'b1, burst_seq[b], 3'b101, 1'b0, 1'b1);
      step();
      if (b < 8) chk("busy_addr_held", addr0, 0);
    end
    chk("busy_release", addr0, 1);

    // back-to-back short INCR bursts: early limit suppresses the hold
    do_reset();
    drive(4'b0001, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step();
    drive(4'b1110, 1'b1, 2'b10, 3'b001, 1'b0, 1'b1); step();
    chk("incr_first_hold", hold0, 1);
    drive(4'b1110, 1'b1, 2'b11, 3'b001, 1'b0, 1'b1); step();
    drive(4'b1110, 1'b1, 2'b10, 3'b001, 1'b0, 1'b1); step();
    drive(4'b1110, 1'b1, 2'b11, 3'b001, 1'b0, 1'b1); step();
    drive(4'b1110, 1'b1, 2'b10, 3'b001, 1'b0, 1'b1); step();
    chk("incr_suppressed_hold", hold0, 0);
    chk("incr_suppressed_grant", addr0, 1);

    // locked transfers keep the grant
    s_addr0 = addr0;
    drive(4'b1111, 1'b1, 2'b10, 3'b000, 1'b1, 1'b1);
    for (int b = 0; b < 5; b++) begin
      step();
      chk("lock_addr", addr0, s_addr0);
    end

    // HREADYM low freezes everything, including a live hold
    drive(4'b1111, 1'b1, 2'b10, 3'b111, 1'b0, 1'b1);
    step();
    s_addr0 = addr0; s_nop0 = nop0; s_hold0 = hold0;
    s_addr1 = addr1; s_nop1 = nop1; s_hold1 = hold1;
    chk("stall_pre_hold", hold0, 1);
    for (int b = 0; b < 3; b++) begin
      drive(4'($urandom_range(0, 15)), 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
      step();
      chk("stall_addr0", addr0, s_addr0);
      chk("stall_nop0", nop0, s_nop0);
      chk("stall_hold0", hold0, s_hold0);
      chk("stall_addr1", addr1, s_addr1);
      chk("stall_nop1", nop1, s_nop1);
      chk("stall_hold1", hold1, s_hold1);
    end
    // reset in the middle of the held burst
    do_reset();

    // fixed priority from port 2
    drive(4'b0100, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1); step();
    chk("fp_start", addr1, 2);
    drive(4'b0011, 1'b1, 2'b10, 3'b000, 1'b0, 1'b1); step();
    chk("fp_lower_wins", addr1, 0);
    do_reset();
    drive(4'b0100, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1); step();
    drive(4'b1000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1); step();
    chk("fp_higher_idx", addr1, 3);
    do_reset();
    drive(4'b0100, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1); step();
    drive(4'b0000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1); step();
    chk("fp_release", nop1, 1);
    chk("fp_release_addr", addr1, 0);

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      drive(4'($urandom_range(0, 15)),
            1'(($urandom % 8) != 0),
            (($urandom % 2) == 0) ? 2'b11 : 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)),
            1'(($urandom % 12) == 0),
            1'(($urandom % 5) != 0));
      step();
      if (($urandom % 150) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
